// File: rtl/bcd_scan_counter_if.sv
// Control and display bundle for the four-digit BCD counter.
// master drives controls; slave is the counter itself.
interface bcd_scan_counter_if;
  logic        en;
  logic        up;
  logic        clr;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] count;
  logic [3:0]  digit;
  logic [3:0]  an;
  logic        wrap;

  modport master (
    output en, up, clr, load, load_val,
    input  count, digit, an, wrap
  );

  modport slave (
    input  en, up, clr, load, load_val,
    output count, digit, an, wrap
  );
endinterface

// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up/down counter with prescaled stepping
// and a free-running multiplexed 7-segment digit scanner.
module bcd_scan_counter #(
  parameter int CNT_DIV  = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input logic               clk,
  input logic               rst_n,
  bcd_scan_counter_if.slave bus
);

  localparam int PW = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_TOP = PW'(CNT_DIV - 1);
  localparam logic [SW-1:0] SCN_TOP = SW'(SCAN_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [1:0]    slot_q, slot_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          wrap_q, wrap_d;
  logic          step;

  function automatic logic [15:0] bcd_inc(
    input logic [15:0] v
  );
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd_dec(
    input logic [15:0] v
  );
    logic [15:0] r;
    logic        b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Out-of-range load nibbles clamp to 9 so count stays legal BCD.
  function automatic logic [15:0] bcd_sat(
    input logic [15:0] v
  );
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
    end
    return r;
  endfunction

  always_comb begin
    step   = bus.en && (pre_q == PRE_TOP);
    pre_d  = pre_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (bus.clr) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (bus.load) begin
      pre_d = '0;
      cnt_d = bcd_sat(bus.load_val);
    end else begin
      if (bus.en) begin
        pre_d = step ? '0 : pre_q + PW'(1);
      end
      if (step) begin
        if (bus.up) begin
          cnt_d  = bcd_inc(cnt_q);
          wrap_d = (cnt_q == 16'h9999);
        end else begin
          cnt_d  = bcd_dec(cnt_q);
          wrap_d = (cnt_q == 16'h0000);
        end
      end
    end
  end

  always_comb begin
    scan_d = scan_q + SW'(1);
    slot_d = slot_q;
    if (scan_q == SCN_TOP) begin
      scan_d = '0;
      slot_d = slot_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      scan_q <= '0;
      slot_q <= '0;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      scan_q <= scan_d;
      slot_q <= slot_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.count = cnt_q;
  assign bus.wrap  = wrap_q;
  assign bus.an    = ~(4'b0001 << slot_q);
  assign bus.digit = cnt_q[{slot_q, 2'b00} +: 4];

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed bench with a decimal reference model and
// a per-cycle output comparison at the falling edge.
module tb_bcd_scan_counter;

  localparam int CD = 2;
  localparam int SD = 3;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bcd_scan_counter_if bus ();

  bcd_scan_counter #(
    .CNT_DIV  (CD),
    .SCAN_DIV (SD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int m_cnt  = 0;
  int m_pre  = 0;
  int m_scan = 0;
  int m_slot = 0;
  bit m_wrap = 1'b0;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'(v / 100 % 10),
            4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int from_ld(input logic [15:0] v);
    int r;
    int d;
    r = 0;
    for (int i = 3; i >= 0; i--) begin
      d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      r = r * 10 + d;
    end
    return r;
  endfunction

  function automatic int exp_digit(input int c, input int s);
    int p;
    p = 1;
    for (int k = 0; k < s; k++) p = p * 10;
    return (c / p) % 10;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  = 0;
      m_pre  = 0;
      m_scan = 0;
      m_slot = 0;
      m_wrap = 1'b0;
    end else begin
      bit stp;
      stp    = bus.en && (m_pre == CD - 1);
      m_wrap = 1'b0;
      if (bus.clr) begin
        m_cnt = 0;
        m_pre = 0;
      end else if (bus.load) begin
        m_cnt = from_ld(bus.load_val);
        m_pre = 0;
      end else begin
        if (bus.en) m_pre = stp ? 0 : m_pre + 1;
        if (stp && bus.up) begin
          m_wrap = (m_cnt == 9999);
          m_cnt  = (m_cnt + 1) % 10000;
        end else if (stp) begin
          m_wrap = (m_cnt == 0);
          m_cnt  = (m_cnt + 9999) % 10000;
        end
      end
      if (m_scan == SD - 1) begin
        m_scan = 0;
        m_slot = (m_slot + 1) % 4;
      end else begin
        m_scan = m_scan + 1;
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      logic [3:0] ean;
      ean         = 4'hF;
      ean[m_slot] = 1'b0;
      chk("m_count", bus.count, to_bcd(m_cnt));
      chk("m_an", {12'd0, bus.an}, {12'd0, ean});
      chk("m_digit", {12'd0, bus.digit},
          16'(exp_digit(m_cnt, m_slot)));
      chk("m_wrap", {15'd0, bus.wrap}, {15'd0, m_wrap});
      chk("m_range", {15'd0, bus.digit > 4'd9}, 16'd0);
    end
  end

  task automatic do_load(input logic [15:0] v);
    @(negedge clk);
    bus.load_val = v;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load     = 1'b0;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_cnt"}, bus.count, 16'h0000);
    chk({nm, "_an"}, {12'd0, bus.an}, 16'h000E);
    chk({nm, "_dig"}, {12'd0, bus.digit}, 16'h0000);
    chk({nm, "_wrap"}, {15'd0, bus.wrap}, 16'h0000);
  endtask

  logic [3:0] an_tab [4];
  int n;

  initial begin
    checks       = 0;
    errors       = 0;
    an_tab[0]    = 4'b1110;
    an_tab[1]    = 4'b1101;
    an_tab[2]    = 4'b1011;
    an_tab[3]    = 4'b0111;
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.up       = 1'b1;
    bus.clr      = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = 16'h0000;
    #1;
    chk_reset("rst0");
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    bus.en = 1'b1;
    repeat (19) @(negedge clk);
    chk("up19", bus.count, 16'h0009);
    @(negedge clk);
    chk("up20", bus.count, 16'h0010);

    do_load(16'h9998);
    repeat (2) @(negedge clk);
    chk("w9999", bus.count, 16'h9999);
    repeat (2) @(negedge clk);
    chk("w0000", bus.count, 16'h0000);
    chk("wrap_hi", {15'd0, bus.wrap}, 16'h0001);
    @(negedge clk);
    chk("wrap_lo", {15'd0, bus.wrap}, 16'h0000);
    @(negedge clk);
    chk("w0001", bus.count, 16'h0001);

    bus.up = 1'b0;
    do_load(16'h0001);
    repeat (2) @(negedge clk);
    chk("d0000", bus.count, 16'h0000);
    repeat (2) @(negedge clk);
    chk("d9999", bus.count, 16'h9999);
    chk("dwrap", {15'd0, bus.wrap}, 16'h0001);
    bus.en = 1'b0;
    do_load(16'h3AF5);
    chk("sat", bus.count, 16'h3995);

    @(negedge clk);
    bus.load_val = 16'h1234;
    bus.load     = 1'b1;
    bus.clr      = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    bus.clr  = 1'b0;
    chk("clr_pri", bus.count, 16'h0000);
    repeat (10) @(negedge clk);
    chk("frozen", bus.count, 16'h0000);

    do_load(16'h4321);
    n = 0;
    while (bus.an !== 4'b0111 && n < 20) begin
      @(negedge clk);
      n++;
    end
    while (bus.an !== 4'b1110 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("scan_sync", {15'd0, n >= 20}, 16'h0000);
    for (int i = 0; i < 12; i++) begin
      chk("scan_an", {12'd0, bus.an},
          {12'd0, an_tab[i/3]});
      chk("scan_dig", {12'd0, bus.digit}, 16'(i/3 + 1));
      @(negedge clk);
    end

    do_load(16'h0057);
    #2 rst_n = 1'b0;
    #1;
    chk_reset("arst");
    @(negedge clk);
    rst_n = 1'b1;

    bus.en = 1'b1;
    bus.up = 1'b1;
    do_load(16'h9999);
    repeat (2) @(negedge clk);
    chk("pre_rst_wrap", {15'd0, bus.wrap}, 16'h0001);
    #2 rst_n = 1'b0;
    #1;
    chk_reset("wrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("no_wrap", {15'd0, bus.wrap}, 16'h0000);
    repeat (4) @(negedge clk);
    chk("post_rst", bus.count, 16'h0002);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
